ipml_fifo_burst_framer: RTL and testbench

IPML_FIFO_BURST_FRAMER -- requirements
Module: ipml_fifo_burst_framer

---
 rtl/ipml_burst_framer_pkg.sv | 8 +
 rtl/ipml_burst_timeout_cnt.sv | 27 ++
 rtl/ipml_fifo_burst_framer.sv | 70 +++++++
 tb/tb_ipml_fifo_burst_framer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ipml_burst_framer_pkg.sv
// ipml_burst_framer_pkg: shared FSM encoding and parameter defaults for the burst framer
package ipml_burst_framer_pkg;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_BURST_LEN_MAX = 16;
  localparam int DEF_LEN_WIDTH     = 5;
  localparam int DEF_TO_WIDTH      = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SEND = 2'd2} state_e;
endpackage

// File: rtl/ipml_burst_timeout_cnt.sv
// ipml_burst_timeout_cnt: idle timer that raises flush once a nonzero timeout elapses
module ipml_burst_timeout_cnt
  import ipml_burst_framer_pkg::*;
#(
  parameter int c_TO_WIDTH = DEF_TO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  xfer,
  input  logic [c_TO_WIDTH-1:0] timeout,
  output logic                  flush,
  output logic                  flush_nxt
);
  logic [c_TO_WIDTH-1:0] cnt;
  logic hit;
  assign hit       = run && timeout != '0 && cnt == timeout;
  assign flush_nxt = hit | (flush & ~xfer);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      flush <= 1'b0;
    end else begin
      cnt   <= run ? cnt + 1'b1 : '0;
      flush <= flush_nxt;
    end
endmodule

// File: rtl/ipml_fifo_burst_framer.sv
// ipml_fifo_burst_framer: frames a prefetch-FIFO word stream into sop/eop bursts,
// closing a short burst once the input has been idle for the timeout.
module ipml_fifo_burst_framer
  import ipml_burst_framer_pkg::*;
#(
  parameter int c_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int c_BURST_LEN_MAX = DEF_BURST_LEN_MAX,
  parameter int c_LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int c_TO_WIDTH      = DEF_TO_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [c_DATA_WIDTH-1:0] in_data,
  input  logic                    in_vld,
  output logic                    in_en,
  input  logic [c_LEN_WIDTH-1:0]  burst_len,
  input  logic [c_TO_WIDTH-1:0]   timeout,
  output logic [c_DATA_WIDTH-1:0] out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    out_sop,
  output logic                    out_eop
);
  localparam logic [c_LEN_WIDTH-1:0] LEN_MAX = c_LEN_WIDTH'(c_BURST_LEN_MAX);
  localparam logic [c_LEN_WIDTH-1:0] ONE     = c_LEN_WIDTH'(1);
  state_e state, state_nxt;
  logic [c_DATA_WIDTH-1:0] hold_data;
  logic [c_LEN_WIDTH-1:0] beat_idx, len_q, beat_nxt, len_nxt, len_eff;
  logic hold_vld, hold_nxt, last, last_nxt, flush, flush_nxt, run, xfer, pop;
  // HOLD emits only once the next word proves this one is not the burst end
  assign hold_vld = state != IDLE;
  assign last     = beat_idx == len_q - ONE;
  assign out_vld  = state == SEND || (state == HOLD && in_vld);
  assign out_eop  = hold_vld & (last | flush);
  assign out_sop  = hold_vld & (beat_idx == '0);
  assign out_data = hold_data;
  assign xfer     = out_vld & out_rdy;
  assign in_en    = ~hold_vld | xfer;
  assign pop      = in_vld & in_en;
  assign run      = hold_vld & ~last & ~in_vld & ~flush;
  assign len_eff  = (burst_len == '0 || burst_len > LEN_MAX) ? LEN_MAX : burst_len;
  always_comb begin
    beat_nxt  = xfer ? (out_eop ? '0 : beat_idx + ONE) : beat_idx;
    len_nxt   = (pop && beat_nxt == '0) ? len_eff : len_q;
    hold_nxt  = pop | (hold_vld & ~xfer);
    last_nxt  = beat_nxt == len_nxt - ONE;
    state_nxt = !hold_nxt ? IDLE : (last_nxt || flush_nxt) ? SEND : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      hold_data <= '0;
      beat_idx  <= '0;
      len_q     <= '0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_nxt;
      len_q    <= len_nxt;
      if (pop) hold_data <= in_data;
    end
  ipml_burst_timeout_cnt #(.c_TO_WIDTH(c_TO_WIDTH)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .xfer      (xfer),
    .timeout   (timeout),
    .flush     (flush),
    .flush_nxt (flush_nxt)
  );
endmodule

// File: tb/tb_ipml_fifo_burst_framer.sv
// tb_ipml_fifo_burst_framer: directed scoreboard bench for the burst framer
module tb_ipml_fifo_burst_framer;
  typedef struct packed {logic [31:0] d; logic sop; logic eop;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data = '0, out_data;
  logic in_vld = 1'b0, in_en, out_vld, out_rdy = 1'b1, out_sop, out_eop;
  logic [4:0] burst_len = 5'd4;
  logic [7:0] timeout = 8'd0;
  int checks = 0, errors = 0, cyc = 0, nbeats = 0, t_prev = 0, t_last = 0;
  bit prev_stall = 0, tog = 0;
  logic [33:0] prev_o = '0;
  exp_t expq[$];
  logic [31:0] src[$];

  ipml_fifo_burst_framer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_en(in_en),
    .burst_len(burst_len), .timeout(timeout), .out_data(out_data), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_sop(out_sop), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load();
    in_vld  = src.size() != 0;
    in_data = in_vld ? src[0] : '0;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (prev_stall) chk("stall_hold", {29'd0, out_vld, out_data, out_sop, out_eop}, {29'd0, 1'b1, prev_o});
    if (out_vld && !out_rdy) chk("stall_in_en", 64'(in_en), 64'd0);
    prev_stall = out_vld && !out_rdy;
    prev_o = {out_data, out_sop, out_eop};
    if (out_vld && out_rdy) begin
      nbeats++;
      t_prev = t_last;
      t_last = cyc;
      if (expq.size() == 0) chk("extra_beat", 64'(expq.size()), 64'd1);
      else begin
        e = expq.pop_front();
        chk("beat", {30'd0, out_data, out_sop, out_eop}, {30'd0, e.d, e.sop, e.eop});
      end
    end
    if (in_vld && in_en) src.delete(0);
    @(posedge clk);
    #1;
    cyc++;
    if (tog) out_rdy = ~out_rdy;
    load();
  endtask

  task automatic send(int n, int len, int base, bit tail);
    for (int i = 0; i < n; i++) begin
      src.push_back(32'(base + i));
      expq.push_back(exp_t'{d: 32'(base + i), sop: (i % len == 0), eop: (i % len == len - 1) || (tail && i == n - 1)});
    end
    load();
  endtask

  task automatic drain(string tag, int budget);
    for (int k = 0; k < budget && expq.size() != 0; k++) tick();
    chk(tag, 64'(expq.size()), 64'd0);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_low"}, {28'd0, out_vld, out_sop, out_eop, in_en, out_data}, {28'd0, 4'b0001, 32'd0});
    src.delete();
    expq.delete();
    load();
    prev_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk({tag, "_rel"}, {28'd0, out_vld, out_sop, out_eop, in_en, out_data}, {28'd0, 4'b0001, 32'd0});
  endtask

  initial begin
    int c0;
    do_reset("rst0");
    // four-beat bursts back to back at full rate
    burst_len = 5'd4;
    timeout = 8'd0;
    c0 = cyc;
    send(12, 4, 0, 1);
    drain("s1_drain", 40);
    chk("s1_rate", 64'(cyc - c0), 64'd13);
    // short burst closed by timeout, next word opens a new burst
    timeout = 8'd5;
    send(2, 4, 100, 1);
    drain("s2_drain", 40);
    chk("s2_flush_lat", 64'(t_last - t_prev), 64'd7);
    send(1, 4, 102, 1);
    drain("s2b_drain", 40);
    // input arriving on the expiry cycle wins over the flush
    timeout = 8'd3;
    send(1, 4, 500, 0);
    repeat (4) tick();
    src.push_back(32'd501);
    expq.push_back(exp_t'{d: 32'd501, sop: 1'b0, eop: 1'b1});
    load();
    drain("s3_drain", 40);
    // burst_len 0 means max length, tail flushed by timeout
    burst_len = 5'd0;
    send(20, 16, 400, 1);
    drain("s4_drain", 80);
    // without timeout the tail word is never released
    timeout = 8'd0;
    send(20, 16, 900, 0);
    repeat (60) tick();
    chk("s4b_pending", 64'(expq.size()), 64'd1);
    chk("s4b_no_vld", 64'(out_vld), 64'd0);
    do_reset("rst1");
    // backpressure toggling every cycle
    burst_len = 5'd4;
    timeout = 8'd4;
    tog = 1;
    send(10, 4, 600, 1);
    drain("s5_drain", 80);
    tog = 0;
    out_rdy = 1'b1;
    // flush pending under stall, then a new word shows up
    timeout = 8'd3;
    out_rdy = 1'b0;
    send(1, 4, 200, 1);
    repeat (10) tick();
    chk("s6_flush_eop", {62'd0, out_vld, out_eop}, 64'd3);
    src.push_back(32'd201);
    expq.push_back(exp_t'{d: 32'd201, sop: 1'b1, eop: 1'b1});
    load();
    repeat (3) tick();
    chk("s6_eop_kept", {62'd0, out_vld, out_eop}, 64'd3);
    out_rdy = 1'b1;
    drain("s6_drain", 40);
    // reset in the middle of an eight-beat burst
    burst_len = 5'd8;
    timeout = 8'd0;
    nbeats = 0;
    send(8, 8, 700, 0);
    for (int k = 0; k < 20 && nbeats < 2; k++) tick();
    chk("s7_beat2", 64'(nbeats), 64'd2);
    do_reset("rst2");
    burst_len = 5'd4;
    timeout = 8'd3;
    send(3, 4, 800, 1);
    drain("s7_drain", 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
